// File: rtl/fpu_pkg.sv
// Shared FPU definitions: word width, IEEE-754 field slices
// and the multiplier scheduler state encoding.
package fpu_pkg;
  localparam int FP_W     = 32;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;
  localparam int MAN_LSB  = 0;
  localparam int EXP_BIAS = 127;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sched_state_t;
endpackage

// File: rtl/fp_mul_scheduler_if.sv
// Request/result bundle between FPU lanes and the
// shared multiplier scheduler.
interface fp_mul_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  res_valid;
  logic [31:0]           res_data;
  logic [IDW-1:0]        res_id;
  logic                  res_ready;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/fp_mul.sv
// Combinational IEEE-754 single multiply, round to
// nearest even, subnormals flushed to zero.
module fp_mul
  import fpu_pkg::*;
(
  input  logic [FP_W-1:0] i_a,
  input  logic [FP_W-1:0] i_b,
  output logic [FP_W-1:0] o_p
);
  logic              w_s;
  logic [7:0]        w_ea, w_eb;
  logic [23:0]       w_ma, w_mb;
  logic              w_za, w_zb, w_ia, w_ib, w_na, w_nb;
  logic [47:0]       w_prod;
  logic              w_norm, w_g, w_st, w_rnd;
  logic [22:0]       w_man;
  logic [23:0]       w_mr;
  logic signed [9:0] w_exp;

  assign w_s  = i_a[SIGN_BIT] ^ i_b[SIGN_BIT];
  assign w_ea = i_a[EXP_MSB:EXP_LSB];
  assign w_eb = i_b[EXP_MSB:EXP_LSB];
  assign w_ma = {1'b1, i_a[MAN_MSB:MAN_LSB]};
  assign w_mb = {1'b1, i_b[MAN_MSB:MAN_LSB]};
  assign w_za = (w_ea == 8'h00);
  assign w_zb = (w_eb == 8'h00);
  assign w_ia = (w_ea == 8'hFF) && (w_ma[22:0] == '0);
  assign w_ib = (w_eb == 8'hFF) && (w_mb[22:0] == '0);
  assign w_na = (w_ea == 8'hFF) && (w_ma[22:0] != '0);
  assign w_nb = (w_eb == 8'hFF) && (w_mb[22:0] != '0);
  assign w_prod = 48'(w_ma) * 48'(w_mb);

  // Normalise, round, then resolve special operands
  always_comb begin
    w_norm = w_prod[47];
    w_man  = w_norm ? w_prod[46:24] : w_prod[45:23];
    w_g    = w_norm ? w_prod[23] : w_prod[22];
    w_st   = w_norm ? |w_prod[22:0] : |w_prod[21:0];
    w_rnd  = w_g & (w_st | w_man[0]);
    w_mr   = {1'b0, w_man} + 24'(w_rnd);
    w_exp  = 10'(w_ea) + 10'(w_eb) - 10'(EXP_BIAS)
           + 10'(w_norm) + 10'(w_mr[23]);
    if (w_na || w_nb || (w_ia && w_zb) || (w_za && w_ib))
      o_p = 32'h7FC0_0000;
    else if (w_ia || w_ib)
      o_p = {w_s, 8'hFF, 23'h0};
    else if (w_za || w_zb)
      o_p = {w_s, 31'h0};
    else if (w_exp >= 10'sd255)
      o_p = {w_s, 8'hFF, 23'h0};
    else if (w_exp <= 10'sd0)
      o_p = {w_s, 31'h0};
    else
      o_p = {w_s, w_exp[7:0], w_mr[22:0]};
  end
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; the pointer
// register is owned by the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDW-1:0]     i_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDW-1:0]     o_idx
);
  // Scan from the slot after the last winner, wrapping once
  always_comb begin : scan
    int   p;
    logic found;
    o_grant = '0;
    o_idx   = '0;
    found   = 1'b0;
    p       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      p = (int'(i_last) + i) % NUM_REQ;
      if (!found && i_req[p]) begin
        o_grant[p] = 1'b1;
        o_idx      = IDW'(p);
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fp_mul_scheduler.sv
// Round-robin scheduler sharing one FP multiplier
// among NUM_REQ requesters, result tagged by ID.
module fp_mul_scheduler
  import fpu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  fp_mul_scheduler_if.slave   bus,
  output logic                busy,
  output logic [31:0]         op_count
);
  sched_state_t      r_state;
  logic [IDW-1:0]    r_last_grant;
  logic [FP_W-1:0]   r_op_a, r_op_b;
  logic [IDW-1:0]    r_op_id;
  logic              r_res_valid;
  logic [FP_W-1:0]   r_res_data;
  logic [IDW-1:0]    r_res_id;
  logic [31:0]       r_op_count;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDW-1:0]     w_idx;
  logic               w_accept;
  logic [FP_W-1:0]    w_prod;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
    .i_req   (bus.req_valid),
    .i_last  (r_last_grant),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  fp_mul u_mul (
    .i_a (r_op_a),
    .i_b (r_op_b),
    .o_p (w_prod)
  );

  assign bus.req_ready = (r_state == IDLE && !rst)
                       ? w_grant : '0;
  assign w_accept      = |bus.req_ready;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_id    = r_res_id;
  assign busy          = (r_state != IDLE);
  assign op_count      = r_op_count;

  // Accept, compute and hand off one request at a time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= IDW'(NUM_REQ - 1);
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_id      <= '0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_id     <= '0;
      r_op_count   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op_a       <= bus.req_a[int'(w_idx)*FP_W +: FP_W];
            r_op_b       <= bus.req_b[int'(w_idx)*FP_W +: FP_W];
            r_op_id      <= w_idx;
            r_last_grant <= w_idx;
            r_state      <= CALC;
          end
        end
        CALC: begin
          r_res_data  <= w_prod;
          r_res_id    <= r_op_id;
          r_res_valid <= 1'b1;
          r_op_count  <= r_op_count + 32'd1;
          r_state     <= DONE;
        end
        DONE: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fp_mul_scheduler.md
# fp_mul_scheduler

Shares one instance of the team's combinational single-precision FP multiplier among NUM_REQ requesters. Round-robin arbitration picks one request at a time. The scheduler latches that request's operands into registers and drives the multiplier from them, then registers the product. The product is returned tagged with the requester ID over a valid/ready handshake. It sits between the issue logic of the FPU lanes and the multiplier datapath, and is the only block allowed to drive the multiplier's inputs.

## Interface
- NUM_REQ, default 4: number of requesters, legal range 2..16.
- IDW, default $clog2(NUM_REQ): width of the requester ID.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_a  in  NUM_REQ*32  operand A for each requester; requester i uses bits [32i+31:32i].
- req_b  in  NUM_REQ*32  operand B, packed the same way as req_a.
- req_ready  out  NUM_REQ  one-hot grant/accept; at most one bit set.
- res_valid  out  1  result available.
- res_data  out  32  product, IEEE-754 single format.
- res_id  out  IDW  index of the requester that owns res_data.
- res_ready  in  1  consumer accepts the result.
- busy  out  1  high whenever state is not IDLE.
- op_count  out  32  number of completed operations; wraps.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - req_ready = grant vector from the round-robin arbiter, ANDed with req_valid. The path is combinational from req_valid.
  - On any req_ready[i]=1: latch op_a=req_a[i], op_b=req_b[i], op_id=i, then go to CALC.
  - With no request, stay in IDLE.
- CALC:
  - The multiplier is driven only from op_a/op_b.
  - Register the multiplier output into res_data and op_id into res_id.
  - Set res_valid, increment op_count, go to DONE.
- DONE:
  - Hold res_valid, res_data and res_id stable.
  - On res_ready=1, clear res_valid and go to IDLE.
- Round-robin:
  - The pointer last_grant updates only on an accepted request.
  - Priority order starts at last_grant+1 modulo NUM_REQ.
  - Reset value is NUM_REQ-1, so requester 0 has top priority after reset.
- Requester rules:
  - Hold req_valid and operands stable until req_ready is seen.
  - Deasserting req_valid before the grant is allowed; the request is then simply not serviced.
- req_ready is 0 in CALC and DONE, whatever req_valid and res_ready are.
- Operand changes on the req_a/req_b ports after acceptance have no effect on the result.
- op_count goes from 0xFFFFFFFF to 0 with no flag.
- Reset mid-operation: the in-flight operation is dropped.
- Reset values:
  - state=IDLE, res_valid=0, res_data=0, res_id=0, op_count=0, last_grant=NUM_REQ-1.
  - req_ready=0 during reset; busy=0.

## Timing
- Request accepted in cycle T (req_valid[i] & req_ready[i] at edge T).
- res_valid=1 from cycle T+2; it is registered at the end of CALC.
- Earliest acceptance of the next request:
  - If res_ready is held high, res_valid drops and the FSM returns to IDLE at edge T+2.
  - The next request can then be accepted in cycle T+3.
  - Peak throughput is 1 operation per 3 cycles.
- res_ready is sampled only in DONE. In IDLE and CALC it is ignored.
- The request-to-grant path is combinational. The result path is fully registered, with no combinational path from res_ready to any output except through state.

## Structure
- Shared package fpu_pkg holds:
  - FP_W=32.
  - The state enum typedef sched_state_t {IDLE, CALC, DONE}.
  - The field-slice constants used across FPU blocks.
- Sub-module rr_arbiter (parameter NUM_REQ):
  - Inputs: req vector, last_grant.
  - Outputs: one-hot grant and grant index.
  - Purely combinational; the pointer register lives in the scheduler.
- The scheduler instantiates the existing multiplier block once.

## Test plan
- Single request: requester 2 sends a=0x40000000, b=0x40400000 in cycle 5.
  - req_ready=0b0100 in cycle 5; res_valid rises in cycle 7 with res_id=2.
  - res_data equals a standalone multiplier instance fed the same operands.
  - op_count=1.
- Round-robin fairness: all 4 requesters held valid, res_ready tied high.
  - Grant order is 0,1,2,3,0,…; accepts are exactly 3 cycles apart; res_id follows the same order.
- Backpressure: res_ready=0 for 10 cycles after res_valid rises.
  - res_valid, res_data and res_id stay stable; req_ready stays 0.
  - busy=1 throughout.
  - The next grant comes the cycle after res_ready is raised.
- Operand isolation: change req_a[1] one cycle after requester 1 is accepted.
  - res_data matches the originally latched operands.
- Asynchronous reset asserted mid-CALC (not on a clock edge).
  - Outputs go to reset values immediately; no result is delivered; op_count=0.
  - After release, requester 0 wins a contention with requester 3.
- op_count wrap: preload by running 2^32 ops via a forced internal value of 0xFFFFFFFF.
  - The next completion yields 0.
